// File: rtl/cu_vertex_cache_arbiter_control.sv
// rtl/cu_vertex_cache_arbiter_control.sv - round-robin vertex cache read arbiter with credits and drain sequencer
module cu_vertex_cache_arbiter_control #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_BITS       = 32,
    parameter int MAX_OUTSTANDING = 16,
    parameter int TAG_BITS        = $clog2(NUM_REQ),
    parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                           clock,
    input  logic                           rst_in,
    input  logic                           enabled_in,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_address_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    output logic                           cache_cmd_valid_out,
    output logic [ADDR_BITS-1:0]           cache_cmd_address_out,
    output logic [TAG_BITS-1:0]            cache_cmd_tag_out,
    input  logic                           rsp_valid_in,
    input  logic [TAG_BITS-1:0]            rsp_tag_in,
    output logic [NUM_REQ-1:0]             rsp_valid_out,
    input  logic                           drain_req_in,
    output logic                           drain_done_out,
    output logic [CNT_BITS+TAG_BITS-1:0]   outstanding_total_out,
    output logic                           error_out
);
    localparam int TOT_BITS = CNT_BITS + TAG_BITS;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic                  enable_q;
    logic [TAG_BITS-1:0]   ptr_q;
    logic [CNT_BITS-1:0]   count_q [NUM_REQ];
    logic [TOT_BITS-1:0]   total_q, total_d;
    logic [NUM_REQ-1:0]    eligible, grant;
    logic                  grant_any;
    logic [TAG_BITS-1:0]   grant_idx, scan_idx;
    logic                  rsp_err, rsp_dec;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            eligible[k] = req_valid_in[k] && enable_q && (state_q == ST_RUN)
                       && (count_q[k] < CNT_BITS'(MAX_OUTSTANDING));
        end
    end

    // Scan upward from the pointer; NUM_REQ is a power of two so the add wraps naturally.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = ptr_q;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = ptr_q + TAG_BITS'(i);
            if (!grant_any && eligible[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
        grant[grant_idx] = grant_any;
    end

    // A completion against an empty counter is flagged but never allowed to underflow.
    assign rsp_err = rsp_valid_in && (count_q[rsp_tag_in] == '0);
    assign rsp_dec = rsp_valid_in && !rsp_err;

    always_comb begin
        total_d = total_q;
        if (grant_any && !rsp_dec) begin
            total_d = total_q + TOT_BITS'(1);
        end else if (rsp_dec && !grant_any) begin
            total_d = total_q - TOT_BITS'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (drain_req_in) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_req_in)          state_d = ST_RUN;
                else if (total_d == '0)     state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!drain_req_in) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            state_q               <= ST_RUN;
            enable_q              <= 1'b0;
            ptr_q                 <= '0;
            total_q               <= '0;
            error_out             <= 1'b0;
            cache_cmd_valid_out   <= 1'b0;
            cache_cmd_address_out <= '0;
            cache_cmd_tag_out     <= '0;
            rsp_valid_out         <= '0;
            for (int k = 0; k < NUM_REQ; k++) count_q[k] <= '0;
        end else begin
            state_q             <= state_d;
            enable_q            <= enabled_in;
            total_q             <= total_d;
            cache_cmd_valid_out <= grant_any;
            rsp_valid_out       <= rsp_valid_in ? (NUM_REQ'(1) << rsp_tag_in) : '0;
            if (rsp_err) error_out <= 1'b1;
            if (grant_any) begin
                ptr_q                 <= grant_idx + TAG_BITS'(1);
                cache_cmd_tag_out     <= grant_idx;
                cache_cmd_address_out <= req_address_in[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (grant[k] && !(rsp_dec && rsp_tag_in == TAG_BITS'(k))) begin
                    count_q[k] <= count_q[k] + CNT_BITS'(1);
                end else if (!grant[k] && rsp_dec && rsp_tag_in == TAG_BITS'(k)) begin
                    count_q[k] <= count_q[k] - CNT_BITS'(1);
                end
            end
        end
    end

    assign req_ready_out         = grant;
    assign drain_done_out        = (state_q == ST_DONE);
    assign outstanding_total_out = total_q;
endmodule

// File: tb/tb_cu_vertex_cache_arbiter_control.sv
// tb/tb_cu_vertex_cache_arbiter_control.sv - scoreboard bench for the vertex cache arbiter
module tb_cu_vertex_cache_arbiter_control;
    logic          clock = 1'b0;
    logic          rst_in;
    logic          enabled_in;
    logic [3:0]    req_valid_in;
    logic [127:0]  req_address_in;
    logic [3:0]    req_ready_out;
    logic          cache_cmd_valid_out;
    logic [31:0]   cache_cmd_address_out;
    logic [1:0]    cache_cmd_tag_out;
    logic          rsp_valid_in;
    logic [1:0]    rsp_tag_in;
    logic [3:0]    rsp_valid_out;
    logic          drain_req_in;
    logic          drain_done_out;
    logic [6:0]    outstanding_total_out;
    logic          error_out;

    cu_vertex_cache_arbiter_control dut (
        .clock                 (clock),
        .rst_in                (rst_in),
        .enabled_in            (enabled_in),
        .req_valid_in          (req_valid_in),
        .req_address_in        (req_address_in),
        .req_ready_out         (req_ready_out),
        .cache_cmd_valid_out   (cache_cmd_valid_out),
        .cache_cmd_address_out (cache_cmd_address_out),
        .cache_cmd_tag_out     (cache_cmd_tag_out),
        .rsp_valid_in          (rsp_valid_in),
        .rsp_tag_in            (rsp_tag_in),
        .rsp_valid_out         (rsp_valid_out),
        .drain_req_in          (drain_req_in),
        .drain_done_out        (drain_done_out),
        .outstanding_total_out (outstanding_total_out),
        .error_out             (error_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        v;
        logic [1:0]  tag;
        logic [31:0] addr;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [3:0]  rsp_q[$];
    logic [31:0] addr[4];
    int          mdl_cnt[4];
    int          mdl_ptr;
    logic        mdl_err;
    logic        exp_open;
    logic [1:0]  last_tag;
    logic [31:0] last_addr;
    int          obs_grants[4];
    int          errors = 0;
    int          checks = 0;

    assign req_address_in = {addr[3], addr[2], addr[1], addr[0]};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int msum();
        int s = 0;
        for (int i = 0; i < 4; i++) s += mdl_cnt[i];
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mdl_cnt[i]    = 0;
            obs_grants[i] = 0;
        end
        mdl_ptr   = 0;
        mdl_err   = 1'b0;
        last_tag  = '0;
        last_addr = '0;
        cmd_q.delete();
        rsp_q.delete();
    endtask

    // One clock: predict/check grant before the edge, check registered outputs after it.
    task automatic tick();
        int   g;
        cmd_t e;
        logic [3:0] r;
        #2;
        g = -1;
        if (exp_open) begin
            for (int i = 0; i < 4; i++) begin
                int k = (mdl_ptr + i) % 4;
                if (g < 0 && req_valid_in[k] && mdl_cnt[k] < 16) g = k;
            end
        end
        chk("ready", req_ready_out, (g >= 0) ? 4'(1 << g) : 4'b0);
        for (int i = 0; i < 4; i++) obs_grants[i] += int'(req_ready_out[i] & req_valid_in[i]);
        if (rsp_valid_in) begin
            rsp_q.push_back(4'(1 << rsp_tag_in));
            if (mdl_cnt[rsp_tag_in] == 0) mdl_err = 1'b1;
            else mdl_cnt[rsp_tag_in]--;
        end else begin
            rsp_q.push_back(4'b0);
        end
        if (g >= 0) begin
            cmd_q.push_back('{1'b1, 2'(g), addr[g]});
            mdl_cnt[g]++;
            mdl_ptr = (g + 1) % 4;
        end else begin
            cmd_q.push_back('{1'b0, 2'b0, 32'b0});
        end
        @(posedge clock);
        #1;
        e = cmd_q.pop_front();
        chk("cmd_valid", cache_cmd_valid_out, e.v);
        if (e.v) begin
            last_tag  = e.tag;
            last_addr = e.addr;
        end
        chk("cmd_tag", cache_cmd_tag_out, last_tag);
        chk("cmd_addr", cache_cmd_address_out, last_addr);
        r = rsp_q.pop_front();
        chk("rsp_valid_out", rsp_valid_out, r);
        chk("total", outstanding_total_out, msum());
        chk("error", error_out, mdl_err);
        rsp_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) addr[i] = $urandom;
    endtask

    task automatic respond(input int tag);
        rsp_valid_in = 1'b1;
        rsp_tag_in   = 2'(tag);
        tick();
    endtask

    task automatic drain_all();
        for (int i = 0; i < 4; i++) begin
            while (mdl_cnt[i] > 0) respond(i);
        end
    endtask

    initial begin
        rst_in       = 1'b1;
        enabled_in   = 1'b0;
        req_valid_in = '0;
        rsp_valid_in = 1'b0;
        rsp_tag_in   = '0;
        drain_req_in = 1'b0;
        exp_open     = 1'b0;
        for (int i = 0; i < 4; i++) addr[i] = 32'h1000_0000 + 32'(i * 64);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", req_ready_out, 4'b0);
        chk("rst_cmd_valid", cache_cmd_valid_out, 1'b0);
        chk("rst_cmd_addr", cache_cmd_address_out, 32'b0);
        chk("rst_total", outstanding_total_out, 7'b0);
        chk("rst_error", error_out, 1'b0);
        chk("rst_done", drain_done_out, 1'b0);
        rst_in     = 1'b0;
        enabled_in = 1'b1;
        req_valid_in = 4'hF;
        tick();
        exp_open = 1'b1;

        // round robin over four continuously valid requesters
        repeat (4) tick();
        chk("rr_total4", outstanding_total_out, 7'd4);
        repeat (4) tick();
        for (int i = 0; i < 4; i++) chk("rr_each2", obs_grants[i], 2);
        req_valid_in = '0;
        drain_all();

        // credit limit on requester 2
        for (int i = 0; i < 4; i++) obs_grants[i] = 0;
        req_valid_in = 4'b0100;
        repeat (18) tick();
        chk("credit_16", obs_grants[2], 16);
        respond(2);
        tick();
        chk("credit_17", obs_grants[2], 17);
        req_valid_in = '0;
        drain_all();

        // grant and response to the same requester in one cycle
        req_valid_in = 4'b0010;
        repeat (3) tick();
        respond(1);
        chk("simul_total3", outstanding_total_out, 7'd3);
        chk("simul_rsp", rsp_valid_out, 4'b0010);
        req_valid_in = '0;
        drain_all();

        // response with nothing outstanding
        respond(3);
        chk("err_set", error_out, 1'b1);
        chk("err_rsp", rsp_valid_out, 4'b1000);
        repeat (2) tick();
        chk("err_sticky", error_out, 1'b1);

        // drain with five reads in flight
        req_valid_in = 4'hF;
        repeat (5) tick();
        req_valid_in = '0;
        drain_req_in = 1'b1;
        tick();
        req_valid_in = 4'hF;
        exp_open     = 1'b0;
        for (int r = 0; r < 5; r++) begin
            int t = 0;
            for (int i = 3; i >= 0; i--) if (mdl_cnt[i] > 0) t = i;
            respond(t);
            chk("drain_done", drain_done_out, r == 4);
        end
        tick();
        chk("done_hold", drain_done_out, 1'b1);
        drain_req_in = 1'b0;
        tick();
        chk("done_exit", drain_done_out, 1'b0);
        exp_open = 1'b1;
        tick();
        req_valid_in = '0;
        drain_all();

        // drain with nothing outstanding
        drain_req_in = 1'b1;
        tick();
        chk("zdrain_1", drain_done_out, 1'b0);
        tick();
        chk("zdrain_2", drain_done_out, 1'b1);
        drain_req_in = 1'b0;
        tick();

        // asynchronous reset in the middle of a burst
        req_valid_in = 4'hF;
        repeat (3) tick();
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_ready", req_ready_out, 4'b0);
        chk("arst_cmd_valid", cache_cmd_valid_out, 1'b0);
        chk("arst_cmd_tag", cache_cmd_tag_out, 2'b0);
        chk("arst_cmd_addr", cache_cmd_address_out, 32'b0);
        chk("arst_total", outstanding_total_out, 7'b0);
        chk("arst_error", error_out, 1'b0);
        @(posedge clock);
        #1;
        rst_in = 1'b0;
        model_reset();
        exp_open = 1'b0;
        tick();
        exp_open = 1'b1;
        tick();
        chk("arst_first_tag", cache_cmd_tag_out, 2'd0);
        respond(2);
        chk("late_rsp_err", error_out, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cu_vertex_cache_arbiter_control.md
Name: cu_vertex_cache_arbiter_control

Overview:
- Shares one vertex cache read port between NUM_REQ compute-unit requesters.
- Round-robin arbitration: one grant per cycle.
- Tags each issued read with the requester index and tracks outstanding reads per requester with credit counters.
- A drain sequencer quiesces the cache path before a cache refill/invalidate phase. Sits between the CU read-request streams and the vertex cache read-command input.

Parameters:
- NUM_REQ, 4, number of requesters (power of two, ≥2).
- ADDR_BITS, 32, vertex address-offset width.
- MAX_OUTSTANDING, 16, per-requester in-flight read limit.
- TAG_BITS, $clog2(NUM_REQ), requester tag width.
- CNT_BITS, $clog2(MAX_OUTSTANDING+1), counter width.

Ports:
- clock, in, 1: single clock.
- rst_in, in, 1: asynchronous, active-high reset.
- enabled_in, in, 1: arbitration enable; registered once internally.
- req_valid_in, in, NUM_REQ: per-requester read-request valid.
- req_address_in, in, NUM_REQ*ADDR_BITS: packed addresses; requester k occupies bits [k*ADDR_BITS +: ADDR_BITS].
- req_ready_out, out, NUM_REQ: one-hot grant (combinational); handshake occurs when valid&ready.
- cache_cmd_valid_out, out, 1: registered command to the vertex cache.
- cache_cmd_address_out, out, ADDR_BITS: granted address.
- cache_cmd_tag_out, out, TAG_BITS: granted requester index.
- rsp_valid_in, in, 1: completion (hit data or miss fill) returned for one tag.
- rsp_tag_in, in, TAG_BITS: requester tag of the completion.
- rsp_valid_out, out, NUM_REQ: registered one-hot completion routed to its requester.
- drain_req_in, in, 1: level request to quiesce.
- drain_done_out, out, 1: high while in DONE.
- outstanding_total_out, out, CNT_BITS+TAG_BITS: sum of all in-flight reads.
- error_out, out, 1: sticky; set on a response whose tag has a zero count.

Behaviour:
- Reset values (rst_in=1, immediate): all outputs 0; all counters 0; RR pointer 0; state RUN; enable register 0.
- Eligibility: requester k is eligible when req_valid_in[k], count[k]<MAX_OUTSTANDING, registered enable=1 and state=RUN.
- Grant selection: the first eligible requester scanning from the RR pointer upward, modulo NUM_REQ. At most one ready bit is high per cycle.
- Grant latency: req_ready_out is combinational in the grant cycle. The cache_cmd_* outputs are registered one cycle later.
- Pointer update: on a grant to k the pointer becomes (k+1) mod NUM_REQ; with no grant it holds.
- Idle command: cache_cmd_valid_out=0 in cycles with no grant. Address and tag hold their last values.
- Counters:
  - count[k] increments on a grant to k.
  - count[k] decrements on rsp_valid_in with tag k.
  - Both in the same cycle: unchanged.
  - The total counter follows the same rules and equals the sum of count[k] at all times.
- Response routing: rsp_valid_out[rsp_tag_in] is asserted 1 cycle after rsp_valid_in; it is 0 otherwise.
- Zero-count response: a response to a tag with count 0 sets error_out (sticky until reset). The counter is not decremented (no underflow), but rsp_valid_out is still routed.
- Saturation: count[k]=MAX_OUTSTANDING blocks requester k only; the others continue to be served.
- FSM states and transitions:
  - RUN: normal arbitration. drain_req_in=1 → DRAIN.
  - DRAIN: no new grants; responses are still accepted and routed. total==0 → DONE. A drop of drain_req_in before then → RUN.
  - DONE: drain_done_out=1, no grants. drain_req_in=0 → RUN on the next cycle.
  - Drain with total already 0: DRAIN lasts exactly one cycle, then DONE.
- Enable deasserted: no grants, state and counters hold, responses are still counted and routed.
- Reset mid-operation: all in-flight tracking is discarded. Late responses after reset raise error_out.

Test Plan:
- Round-robin: all 4 requesters hold valid continuously → grants k=0,1,2,3,0,… one per cycle. cache_cmd_tag_out follows 1 cycle later. Total count reaches 4 after 4 grants with no responses.
- Credit limit: only requester 2 is valid, no responses → exactly 16 grants, then ready[2]=0. One rsp with tag 2 → ready[2]=1 on the next cycle, then 17 grants in total.
- Simultaneous grant and response: grant to 1 and rsp tag 1 in the same cycle with count[1]=3 → count[1] stays 3, rsp_valid_out=4'b0010 next cycle.
- Drain: 5 reads outstanding, then drain_req_in=1 → no grants. After the 5th response drain_done_out=1 the next cycle. drain_req_in=0 → grants resume within 1 cycle.
- Error: rsp tag 3 with count[3]=0 → error_out=1 and stays high; count[3] stays 0; rsp_valid_out=4'b1000.
- Async reset: assert rst_in mid-burst between clock edges → all outputs 0 immediately, state RUN, pointer 0, first post-reset grant goes to requester 0.
